cdc_2phase_rx_arb: RTL

- Multi-channel destination-side receiver for two-phase (toggle) request/acknowledge crossings.
- Synchronises NumChannels asynchronous request toggles into the local clock domain with a configurable synchroniser depth.
- Captures each channel's data, returns a toggle acknowledge, and merges all channels round-robin onto one valid/ready output stream tagged with the channel index.
- Sits at the boundary of a local domain, facing NumChannels independent source-side senders.

---
 rtl/cdc_2phase_rx_arb.sv | 95 +++++++++
 1 files changed

// File: rtl/cdc_2phase_rx_arb.sv
// Destination-side receiver for NumChannels two-phase req/ack crossings.
// It synchronises each request toggle and merges the channels round-robin onto one valid/ready stream.
module cdc_2phase_rx_arb #(
  parameter  int NumChannels = 4,
  parameter  int DataWidth   = 32,
  parameter  int SyncStages  = 2,
  localparam int IdxWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChannels-1:0]         chan_en_i,
  input  logic [NumChannels-1:0]         async_req_i,
  output logic [NumChannels-1:0]         async_ack_o,
  input  logic [NumChannels*DataWidth-1:0] async_data_i,
  output logic [DataWidth-1:0]           dst_data_o,
  output logic [IdxWidth-1:0]            dst_idx_o,
  output logic                           dst_valid_o,
  input  logic                           dst_ready_i
);

  logic [NumChannels-1:0][SyncStages-1:0] sync_q, sync_d;
  logic [NumChannels-1:0] req_s;
  logic [NumChannels-1:0] ack_q, ack_d;
  logic [NumChannels-1:0] pending;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic [IdxWidth-1:0]    rr_q, rr_d;
  logic [IdxWidth-1:0]    grant;
  logic                   valid_q, valid_d;
  logic                   found;
  logic                   load;

  always_comb begin
    for (int i = 0; i < NumChannels; i++) begin
      sync_d[i] = {sync_q[i][SyncStages-2:0], async_req_i[i]};
      req_s[i]  = sync_q[i][SyncStages-1];
    end
  end

  // A channel has work when its synchronised request differs from the ack we last returned.
  assign pending = (req_s ^ ack_q) & chan_en_i;
  assign load    = (|pending) && (!valid_q || dst_ready_i);

  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NumChannels; k++) begin
      if (!found && pending[(int'(rr_q) + k) % NumChannels]) begin
        found = 1'b1;
        grant = IdxWidth'((int'(rr_q) + k) % NumChannels);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ack_d   = ack_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d      = 1'b1;
      data_d       = async_data_i[int'(grant)*DataWidth +: DataWidth];
      idx_d        = grant;
      ack_d[grant] = ~ack_q[grant];
      rr_d         = IdxWidth'((int'(grant) + 1) % NumChannels);
    end else if (valid_q && dst_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
    end
  end

  assign async_ack_o = ack_q;
  assign dst_data_o  = data_q;
  assign dst_idx_o   = idx_q;
  assign dst_valid_o = valid_q;

endmodule
